// File: rtl/sdp_y_op_sched_pkg.sv
// Shared types for the SDP Y operand scheduler: operand modes, FSM states, counter width.
package sdp_y_op_sched_pkg;

    localparam int unsigned SDP_Y_OP_CNT_W = 13;

    typedef enum logic [1:0] {
        LAYER = 2'd0,
        CHAN  = 2'd1,
        ELEM  = 2'd2
    } op_mode_e;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        SERVE = 2'd2,
        DONE  = 2'd3
    } sched_state_e;

    // Encoding 3 is reserved and behaves as per-layer.
    function automatic op_mode_e decode_op_mode(input logic [1:0] mode);
        case (mode)
            2'd1:    decode_op_mode = CHAN;
            2'd2:    decode_op_mode = ELEM;
            default: decode_op_mode = LAYER;
        endcase
    endfunction

endpackage

// File: rtl/nv_nvdla_sdp_y_op_hold.sv
// Single-entry valid/data holding register; flush beats load beats consume.
module nv_nvdla_sdp_y_op_hold
    import sdp_y_op_sched_pkg::*;
#(
    parameter int unsigned DW = 32
) (
    input  logic          clk,
    input  logic          rstn,
    input  logic          load,
    input  logic [DW-1:0] load_pd,
    input  logic          consume,
    input  logic          flush,
    output logic          valid,
    output logic [DW-1:0] pd
);

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            valid <= 1'b0;
            pd    <= '0;
        end else if (flush) begin
            valid <= 1'b0;
            pd    <= '0;
        end else if (load) begin
            valid <= 1'b1;
            pd    <= load_pd;
        end else if (consume) begin
            valid <= 1'b0;
        end
    end

endmodule

// File: rtl/nv_nvdla_sdp_y_op_sched.sv
// Operand scheduler for one Y-int-core operand port (per-layer / per-channel / per-element).
// Optional feature: define SDP_Y_OP_PREFETCH_EN for a prefetch slot giving bubble-free channel changes.
module nv_nvdla_sdp_y_op_sched
    import sdp_y_op_sched_pkg::*;
#(
    parameter int unsigned EW_OC_DW = 32,
    parameter int unsigned CNT_W    = SDP_Y_OP_CNT_W
) (
    input  logic                nvdla_core_clk,
    input  logic                nvdla_core_rstn,
    input  logic [1:0]          cfg_op_mode,
    input  logic [EW_OC_DW-1:0] cfg_op,
    input  logic [CNT_W-1:0]    cfg_width,
    input  logic [CNT_W-1:0]    cfg_height,
    input  logic [CNT_W-1:0]    cfg_channel,
    input  logic                op_start,
    input  logic                op_in_pvld,
    output logic                op_in_prdy,
    input  logic [EW_OC_DW-1:0] op_in_pd,
    output logic                op_out_pvld,
    input  logic                op_out_prdy,
    output logic [EW_OC_DW-1:0] op_out_pd,
    output logic                busy,
    output logic                layer_done
);

    sched_state_e        state;
    sched_state_e        state_nxt;
    op_mode_e            mode_q;
    logic [EW_OC_DW-1:0] op_q;
    logic [CNT_W-1:0]    w_q;
    logic [CNT_W-1:0]    h_q;
    logic [CNT_W-1:0]    c_q;
    logic [CNT_W-1:0]    x_cnt;
    logic [CNT_W-1:0]    y_cnt;
    logic [CNT_W-1:0]    ch_cnt;

    logic                in_serve;
    logic                in_fetch;
    logic                out_xfer;
    logic                in_xfer;
    logic                x_last;
    logic                y_last;
    logic                ch_last;
    logic                elem_wrap;

    logic                hold_load;
    logic [EW_OC_DW-1:0] hold_load_pd;
    logic                hold_consume;
    logic                hold_flush;
    logic                hold_valid;
    logic [EW_OC_DW-1:0] hold_pd;

    assign in_serve   = (state == SERVE);
    assign in_fetch   = (state == FETCH);
    assign busy       = in_fetch | in_serve;
    assign layer_done = (state == DONE);
    assign out_xfer   = op_out_pvld & op_out_prdy;
    assign in_xfer    = op_in_pvld & op_in_prdy;
    assign x_last     = (x_cnt == w_q);
    assign y_last     = (y_cnt == h_q);
    assign ch_last    = (ch_cnt == c_q);
    assign elem_wrap  = in_serve & out_xfer & x_last & y_last;
    assign hold_flush = (state == DONE);

`ifdef SDP_Y_OP_PREFETCH_EN
    logic                pf_load;
    logic                pf_consume;
    logic                pf_valid;
    logic [EW_OC_DW-1:0] pf_pd;
    logic [CNT_W:0]      fetch_cnt;
    logic                fetch_more;

    // Caps prefetch at cfg_channel+1 operands per layer.
    assign fetch_more = (fetch_cnt <= {1'b0, c_q});

    always_ff @(posedge nvdla_core_clk or negedge nvdla_core_rstn) begin
        if (!nvdla_core_rstn) begin
            fetch_cnt <= '0;
        end else if (state == IDLE && op_start) begin
            fetch_cnt <= '0;
        end else if (in_xfer && mode_q == CHAN) begin
            fetch_cnt <= fetch_cnt + (CNT_W + 1)'(1);
        end
    end

    nv_nvdla_sdp_y_op_hold #(
        .DW (EW_OC_DW)
    ) u_pf (
        .clk     (nvdla_core_clk),
        .rstn    (nvdla_core_rstn),
        .load    (pf_load),
        .load_pd (op_in_pd),
        .consume (pf_consume),
        .flush   (hold_flush),
        .valid   (pf_valid),
        .pd      (pf_pd)
    );
`endif

    nv_nvdla_sdp_y_op_hold #(
        .DW (EW_OC_DW)
    ) u_hold (
        .clk     (nvdla_core_clk),
        .rstn    (nvdla_core_rstn),
        .load    (hold_load),
        .load_pd (hold_load_pd),
        .consume (hold_consume),
        .flush   (hold_flush),
        .valid   (hold_valid),
        .pd      (hold_pd)
    );

    always_comb begin
        op_out_pvld = 1'b0;
        op_out_pd   = '0;
        op_in_prdy  = 1'b0;
        if (in_fetch) begin
            op_in_prdy = 1'b1;
        end else if (in_serve) begin
            case (mode_q)
                CHAN: begin
                    op_out_pvld = hold_valid;
                    op_out_pd   = hold_pd;
`ifdef SDP_Y_OP_PREFETCH_EN
                    op_in_prdy  = ~pf_valid & fetch_more;
`endif
                end
                ELEM: begin
                    op_out_pvld = op_in_pvld;
                    op_out_pd   = op_in_pd;
                    op_in_prdy  = op_out_prdy;
                end
                default: begin
                    op_out_pvld = 1'b1;
                    op_out_pd   = op_q;
                end
            endcase
        end
    end

    // At a channel boundary the next operand comes from the prefetch slot, or straight
    // from op_in when it arrives on the boundary cycle; otherwise the hold reg drains.
    always_comb begin
        hold_load    = 1'b0;
        hold_load_pd = op_in_pd;
        hold_consume = 1'b0;
`ifdef SDP_Y_OP_PREFETCH_EN
        pf_load      = 1'b0;
        pf_consume   = 1'b0;
`endif
        if (in_fetch && in_xfer) begin
            hold_load = 1'b1;
        end else if (in_serve && mode_q == CHAN) begin
            if (elem_wrap) begin
`ifdef SDP_Y_OP_PREFETCH_EN
                if (!ch_last && pf_valid) begin
                    hold_load    = 1'b1;
                    hold_load_pd = pf_pd;
                    pf_consume   = 1'b1;
                end else if (!ch_last && in_xfer) begin
                    hold_load    = 1'b1;
                end else begin
                    hold_consume = 1'b1;
                end
`else
                hold_consume = 1'b1;
`endif
            end
`ifdef SDP_Y_OP_PREFETCH_EN
            else if (in_xfer) begin
                pf_load = 1'b1;
            end
`endif
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (op_start) begin
                    state_nxt = (decode_op_mode(cfg_op_mode) == CHAN) ? FETCH : SERVE;
                end
            end
            FETCH: begin
                if (in_xfer) begin
                    state_nxt = SERVE;
                end
            end
            SERVE: begin
                if (elem_wrap) begin
                    if (ch_last) begin
                        state_nxt = DONE;
                    end else if (mode_q == CHAN) begin
`ifdef SDP_Y_OP_PREFETCH_EN
                        state_nxt = (pf_valid || in_xfer) ? SERVE : FETCH;
`else
                        state_nxt = FETCH;
`endif
                    end
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge nvdla_core_clk or negedge nvdla_core_rstn) begin
        if (!nvdla_core_rstn) begin
            state  <= IDLE;
            mode_q <= LAYER;
            op_q   <= '0;
            w_q    <= '0;
            h_q    <= '0;
            c_q    <= '0;
            x_cnt  <= '0;
            y_cnt  <= '0;
            ch_cnt <= '0;
        end else begin
            state <= state_nxt;
            if (state == IDLE && op_start) begin
                mode_q <= decode_op_mode(cfg_op_mode);
                op_q   <= cfg_op;
                w_q    <= cfg_width;
                h_q    <= cfg_height;
                c_q    <= cfg_channel;
                x_cnt  <= '0;
                y_cnt  <= '0;
                ch_cnt <= '0;
            end else if (in_serve && out_xfer) begin
                if (x_last) begin
                    x_cnt <= '0;
                    if (y_last) begin
                        y_cnt  <= '0;
                        ch_cnt <= ch_last ? '0 : ch_cnt + CNT_W'(1);
                    end else begin
                        y_cnt <= y_cnt + CNT_W'(1);
                    end
                end else begin
                    x_cnt <= x_cnt + CNT_W'(1);
                end
            end
        end
    end

endmodule
